// File: rtl/regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the register file's single write port between two requesters:
//   port 0 : ALU writeback (fixed priority)
//   port 1 : IO/load unit (gets priority after STARVE_LIMIT lost cycles)
// Also runs a synchronous clear sweep that issues rf_reset to every register
// in turn, so software can clear the file without pulsing reset_all.
// All rf_* outputs, last_src, clr_busy and clr_done are registered.
// p0_ready/p1_ready are combinational.
//
// Optional feature macro: ZERO_REG_HARDWIRED_EN
//   When defined, a transfer to address 0 is accepted but produces neither
//   rf_load nor rf_reset; last_src is still updated. The clear sweep still
//   resets address 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_all  in   asynchronous active-high reset of all state
//   hold       in   processor stall; no grants while high
//   pN_valid   in   request from port N
//   pN_ready   out  port N accepted this cycle (combinational)
//   pN_addr    in   target register
//   pN_data    in   write data
//   pN_clr     in   1 = zero the register instead of writing data
//   clr_start  in   pulse that starts the clear sweep
//   clr_busy   out  sweep in progress
//   clr_done   out  one-cycle pulse when the sweep completes
//   rf_load    out  register file load
//   rf_reset   out  register file per-register reset
//   rf_addr    out  register file addr_a
//   rf_din     out  register file d_in
//   last_src   out  source of the current rf_* command (0 = p0, 1 = p1)
// ----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int unsigned NUM_REGS     = 8,
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_all,
    input  logic              hold,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data,
    input  logic              p0_clr,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    input  logic              p1_clr,

    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,

    output logic              rf_load,
    output logic              rf_reset,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_din,
    output logic              last_src
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  STARVE_TH = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  starve_q, starve_d;

    logic              rf_load_q, rf_load_d;
    logic              rf_reset_q, rf_reset_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_din_q, rf_din_d;
    logic              last_src_q, last_src_d;
    logic              clr_busy_q, clr_busy_d;
    logic              clr_done_q, clr_done_d;

    logic              can_grant;
    logic              p1_pri;
    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_clr;
    logic              wr_skip;

    // Grant decision; ready is forced low during reset so outputs read 0.
    always_comb begin
        can_grant = (state_q == ST_IDLE) && !hold && !clr_start && !reset_all;
        p1_pri    = (starve_q >= STARVE_TH) && p1_valid;
        gnt1      = can_grant && p1_valid && (p1_pri || !p0_valid);
        gnt0      = can_grant && p0_valid && !p1_pri;
    end

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

    // Payload of the granted port.
    always_comb begin
        sel_addr = gnt1 ? p1_addr : p0_addr;
        sel_data = gnt1 ? p1_data : p0_data;
        sel_clr  = gnt1 ? p1_clr  : p0_clr;
    end

    // Writes to register 0 are swallowed when it is hardwired to zero.
`ifdef ZERO_REG_HARDWIRED_EN
    assign wr_skip = (sel_addr == '0);
`else
    assign wr_skip = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        starve_d   = starve_q;
        rf_load_d  = 1'b0;
        rf_reset_d = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_din_d   = rf_din_q;
        last_src_d = last_src_q;
        clr_busy_d = clr_busy_q;
        clr_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Counts every unstalled IDLE cycle in which port 1 waits,
                // including the cycle a sweep starts.
                if (!hold && p1_valid && !gnt1 && (starve_q != CNT_MAX)) begin
                    starve_d = starve_q + CNT_W'(1);
                end
                if (gnt1) begin
                    starve_d = '0;
                end

                if (clr_start) begin
                    state_d    = ST_CLEAR;
                    idx_d      = '0;
                    clr_busy_d = 1'b1;
                end else if (gnt0 || gnt1) begin
                    last_src_d = gnt1;
                    if (!wr_skip) begin
                        rf_addr_d = sel_addr;
                        if (sel_clr) begin
                            rf_reset_d = 1'b1;
                            rf_din_d   = '0;
                        end else begin
                            rf_load_d = 1'b1;
                            rf_din_d  = sel_data;
                        end
                    end
                end
            end

            ST_CLEAR: begin
                // One register per cycle; hold does not pause the sweep.
                rf_reset_d = 1'b1;
                rf_addr_d  = idx_q;
                idx_d      = idx_q + ADDR_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d    = ST_IDLE;
                    idx_d      = '0;
                    clr_busy_d = 1'b0;
                    clr_done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            starve_q   <= '0;
            rf_load_q  <= 1'b0;
            rf_reset_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_din_q   <= '0;
            last_src_q <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            starve_q   <= starve_d;
            rf_load_q  <= rf_load_d;
            rf_reset_q <= rf_reset_d;
            rf_addr_q  <= rf_addr_d;
            rf_din_q   <= rf_din_d;
            last_src_q <= last_src_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign rf_load  = rf_load_q;
    assign rf_reset = rf_reset_q;
    assign rf_addr  = rf_addr_q;
    assign rf_din   = rf_din_q;
    assign last_src = last_src_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port (load/reset/addr_a/d_in) between two requesters: ALU writeback (port 0) and the IO/load unit (port 1). Port 0 has fixed priority, and an anti-starvation counter protects port 1. The block also runs a synchronous clear sweep that zeroes every register in turn, so software can clear the file without pulsing the asynchronous reset. All outputs to the register file are registered.

Parameters:
NUM_REGS, 8, number of registers to address and sweep
ADDR_W, 3, register address width
DATA_W, 8, data width
STARVE_LIMIT, 4, consecutive lost cycles after which port 1 takes priority (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset_all  in  1  asynchronous, active-high reset of all state
hold  in  1  processor stall; while 1, no grants
p0_valid  in  1  ALU writeback request
p0_ready  out  1  port 0 accepted this cycle (combinational)
p0_addr  in  ADDR_W  target register
p0_data  in  DATA_W  write data
p0_clr  in  1  1 = zero the register instead of writing data
p1_valid / p1_ready / p1_addr / p1_data / p1_clr  same as port 0, IO/load unit
clr_start  in  1  pulse that starts the clear sweep
clr_busy  out  1  sweep in progress
clr_done  out  1  one-cycle pulse when the sweep completes
rf_load  out  1  to register file load
rf_reset  out  1  to register file per-register reset
rf_addr  out  ADDR_W  to register file addr_a
rf_din  out  DATA_W  to register file d_in
last_src  out  1  source of the current rf_* command (0 = p0, 1 = p1)

Behaviour:
- Reset: while reset_all=1, all outputs are 0, FSM is IDLE and starve_cnt=0.
- Handshake: a transfer occurs when pN_valid && pN_ready. At most one ready is high per cycle. ready never depends on ready. A requester holds addr/data/clr stable until it is accepted.
- Grant, in IDLE with hold=0:
  - starve_cnt >= STARVE_LIMIT and p1_valid: grant p1.
  - else p0_valid: grant p0.
  - else p1_valid: grant p1.
- No grant while hold=1, in CLEAR, or in the cycle clr_start is sampled in IDLE.
- Latency: a transfer in cycle N drives rf_* in cycle N+1, for exactly one cycle.
  - clr=0: rf_load=1, rf_reset=0, rf_din=data.
  - clr=1: rf_reset=1, rf_load=0, rf_din=0.
  - With no transfer, rf_load=rf_reset=0. rf_addr, rf_din and last_src hold their last values.
- starve_cnt (saturating, 4 bits):
  - increments when p1_valid && !p1_ready && state==IDLE && hold=0.
  - clears on a p1 transfer.
  - holds otherwise.
- FSM:
  - IDLE -> CLEAR on clr_start=1. idx=0, clr_busy=1 from the next cycle.
  - CLEAR: each cycle, rf_reset=1, rf_addr=idx (registered), then idx++.
    - After idx=NUM_REGS-1 is issued: -> IDLE, clr_done=1 for one cycle, clr_busy=0.
  - clr_start is ignored in CLEAR. hold does not pause the sweep.
  - The sweep takes exactly NUM_REGS cycles of rf_reset.
- Simultaneous events:
  - clr_start and a valid request in the same IDLE cycle: the sweep wins and the request waits, ready=0.
  - Both ports valid: arbitrate per the grant rules; the loser keeps valid high.
- reset_all mid-sweep aborts immediately: back to IDLE, no clr_done.
- Width: addr/data pass through unmodified. idx is ADDR_W bits, compared against NUM_REGS-1.

Optional Feature:
ZERO_REG_HARDWIRED_EN
- Defined:
  - A transfer with addr==0 is accepted (ready as normal) but produces no rf_load and no rf_reset. last_src is still updated.
  - The clear sweep still issues rf_reset to address 0.
- Undefined: address 0 is an ordinary register.

Test Plan:
- Reset: assert reset_all mid-run -> all outputs 0 in the same cycle, state IDLE, starve_cnt=0.
- Both ports valid: p0 (addr 2, data 0x5A), p1 (addr 3, data 0x11) -> p0 granted first; next cycle rf_load=1, rf_addr=2, rf_din=0x5A, last_src=0.
- Starvation: p0_valid held high, p1 valid, STARVE_LIMIT=4 -> p1 loses 4 cycles, is granted in cycle 5; one cycle later rf_addr=p1_addr, last_src=1.
- Clear sweep: clr_start pulse with p0 valid -> 8 consecutive cycles of rf_reset=1 with rf_addr 0..7; p0_ready=0 throughout; clr_done pulses once; p0 granted the cycle after the sweep ends.
- Hold and clear request: hold=1 with p1 valid, p1_clr=1, addr 5 -> no ready while held; release hold -> rf_reset=1, rf_load=0, rf_addr=5.
- ZERO_REG_HARDWIRED_EN defined, p0 write to addr 0, data 0xFF -> p0_ready=1, rf_load stays 0.
